asi_usr_arb_mem: RTL and testbench

//   User-side back end of the AXI slave interface. Arbitrates burst access between the read engine
//   (usr_rrequest/usr_rgrant) and write engine (usr_wrequest/usr_wgrant). Serves both from an
//   on-chip word-addressed memory with SLV_WS-cycle read latency and byte-strobed writes.

---
 rtl/asi_usr_arb_mem.sv | 189 ++++++++++++++++++
 tb/tb_asi_usr_arb_mem.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/asi_usr_arb_mem.sv
// rtl/asi_usr_arb_mem.sv - burst arbiter and on-chip memory behind the AXI slave read/write engines
module asi_usr_arb_mem #(
    parameter int AXI_DW    = 128,
    parameter int AXI_AW    = 40,
    parameter int AXI_SW    = 3,
    parameter int AXI_BYTES = AXI_DW / 8,
    parameter int MEM_AW    = 10,
    parameter int SLV_WS    = 1,
    parameter int SLV_MAXSZ = $clog2(AXI_BYTES),
    parameter int ASI_ARB   = 0,
    parameter int ARB_MAXB  = 4
) (
    input  logic                 usr_clk,
    input  logic                 usr_reset,
    input  logic                 usr_rrequest,
    output logic                 usr_rgrant,
    input  logic [AXI_AW-1:0]    usr_raddr,
    input  logic                 usr_re,
    input  logic                 usr_rlast,
    input  logic [AXI_SW-1:0]    usr_rsize,
    output logic [AXI_DW-1:0]    usr_rdata,
    output logic                 usr_rsize_error,
    input  logic                 usr_wrequest,
    output logic                 usr_wgrant,
    input  logic [AXI_AW-1:0]    usr_waddr,
    input  logic                 usr_we,
    input  logic                 usr_wlast,
    input  logic [AXI_SW-1:0]    usr_wsize,
    input  logic [AXI_DW-1:0]    usr_wdata,
    input  logic [AXI_BYTES-1:0] usr_wstrb,
    output logic                 usr_wsize_error
);

    localparam int BOFF  = $clog2(AXI_BYTES);
    localparam int DEPTH = 1 << MEM_AW;
    localparam int SW    = $clog2(ARB_MAXB + 1);

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_RD   = 2'd1;
    localparam logic [1:0] ARB_WR   = 2'd2;

    localparam logic [1:0]    PRIO_ST    = (ASI_ARB != 0) ? ARB_RD : ARB_WR;
    localparam logic [SW-1:0] STREAK_MAX = SW'(ARB_MAXB);
    localparam logic [SW-1:0] STREAK_ONE = SW'(1);
    localparam logic [31:0]   MAXSZ_U    = SLV_MAXSZ;

    logic [1:0]    st;
    logic [1:0]    st_nxt;
    logic [1:0]    pick;
    logic [SW-1:0] streak;
    logic [SW-1:0] streak_nxt;
    logic          burst_end;
    logic          abandon;

    assign usr_rgrant = (st == ARB_RD);
    assign usr_wgrant = (st == ARB_WR);

    // Size codes beyond one full bus beat are reported; memory access is unaffected.
    assign usr_rsize_error = (32'(usr_rsize) > MAXSZ_U);
    assign usr_wsize_error = (32'(usr_wsize) > MAXSZ_U);

    // Candidate owner from the current requests; the streak limit hands the bus to the waiting side.
    always_comb begin
        pick = ARB_IDLE;
        if (usr_rrequest && usr_wrequest) begin
            if ((streak == STREAK_MAX) && (st != ARB_IDLE))
                pick = (st == ARB_RD) ? ARB_WR : ARB_RD;
            else
                pick = PRIO_ST;
        end else if (usr_rrequest) begin
            pick = ARB_RD;
        end else if (usr_wrequest) begin
            pick = ARB_WR;
        end
    end

    // Next owner: re-arbitrate at idle or on the last beat, drop to idle if the owner went away.
    always_comb begin
        st_nxt     = st;
        streak_nxt = streak;
        burst_end  = ((st == ARB_RD) && usr_re && usr_rlast) ||
                     ((st == ARB_WR) && usr_we && usr_wlast);
        abandon    = ((st == ARB_RD) && !usr_rrequest && !usr_re) ||
                     ((st == ARB_WR) && !usr_wrequest && !usr_we);
        if (st == 2'd3) begin
            st_nxt     = ARB_IDLE;
            streak_nxt = '0;
        end else if ((st == ARB_IDLE) || burst_end) begin
            st_nxt = pick;
            if (pick == ARB_IDLE)
                streak_nxt = '0;
            else if (pick != st)
                streak_nxt = STREAK_ONE;
            else if (streak != STREAK_MAX)
                streak_nxt = streak + STREAK_ONE;
        end else if (abandon) begin
            st_nxt     = ARB_IDLE;
            streak_nxt = '0;
        end
    end

    // Arbiter state and burst streak registers.
    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            st     <= ARB_IDLE;
            streak <= '0;
        end else begin
            st     <= st_nxt;
            streak <= streak_nxt;
        end
    end

    logic [AXI_DW-1:0] mem [DEPTH];
    logic [MEM_AW-1:0] widx;
    logic [MEM_AW-1:0] ridx;
    logic [AXI_DW-1:0] rd_word;

    assign widx    = usr_waddr[BOFF +: MEM_AW];
    assign ridx    = usr_raddr[BOFF +: MEM_AW];
    assign rd_word = mem[ridx];

    // Address bits outside the word index wrap the memory and are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{usr_raddr[AXI_AW-1:BOFF+MEM_AW], usr_raddr[BOFF-1:0],
                                usr_waddr[AXI_AW-1:BOFF+MEM_AW], usr_waddr[BOFF-1:0]};

    // Byte-strobed write port; contents are deliberately left unreset.
    always_ff @(posedge usr_clk) begin
        if (usr_we) begin
            for (int b = 0; b < AXI_BYTES; b++) begin
                if (usr_wstrb[b])
                    mem[widx][b*8 +: 8] <= usr_wdata[b*8 +: 8];
            end
        end
    end

    // fin_v/fin_d: the read that lands on usr_rdata at the coming edge.
    logic              fin_v;
    logic [AXI_DW-1:0] fin_d;
    logic [AXI_DW-1:0] rdata_q;

    generate
        if (SLV_WS <= 1) begin : g_short
            assign fin_v = usr_re;
            assign fin_d = rd_word;
        end else begin : g_pipe
            logic [SLV_WS-2:0] v_q;
            logic [AXI_DW-1:0] d_q [SLV_WS-1];

            // Valid bits of in-flight reads; cleared on reset so pending reads are dropped.
            always_ff @(posedge usr_clk) begin
                if (usr_reset) begin
                    v_q <= '0;
                end else begin
                    v_q[0] <= usr_re;
                    for (int i = 1; i < SLV_WS - 1; i++)
                        v_q[i] <= v_q[i-1];
                end
            end

            // Data of in-flight reads, sampled at the read strobe edge.
            always_ff @(posedge usr_clk) begin
                d_q[0] <= rd_word;
                for (int i = 1; i < SLV_WS - 1; i++)
                    d_q[i] <= d_q[i-1];
            end

            assign fin_v = v_q[SLV_WS-2];
            assign fin_d = d_q[SLV_WS-2];
        end
    endgenerate

    // Output register holds the most recent completed read.
    always_ff @(posedge usr_clk) begin
        if (usr_reset)
            rdata_q <= '0;
        else if (fin_v)
            rdata_q <= fin_d;
    end

    generate
        if (SLV_WS == 0) begin : g_comb_out
            assign usr_rdata = usr_re ? rd_word : rdata_q;
        end else begin : g_reg_out
            assign usr_rdata = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_asi_usr_arb_mem.sv
// tb/tb_asi_usr_arb_mem.sv - directed self-checking bench for asi_usr_arb_mem
module tb_asi_usr_arb_mem;

    logic          usr_clk = 1'b0;
    logic          usr_reset;
    logic          rreq, re, rlast, wreq, we, wlast;
    logic [39:0]   raddr, waddr;
    logic [2:0]    rsize, wsize;
    logic [127:0]  wdata;
    logic [15:0]   wstrb;

    logic          a_rgrant, a_wgrant, a_rse, a_wse;
    logic          b_rgrant, b_wgrant, b_rse, b_wse;
    logic          c_rgrant, c_wgrant, c_rse, c_wse;
    logic [127:0]  a_rdata, b_rdata, c_rdata;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] W_FULL  = 128'h0123456789ABCDEF_0123456789ABCDEF;
    localparam logic [127:0] W_STRB  = 128'h0123456789ABCDEF_0123456789ABCDFF;
    localparam logic [127:0] W_ALIAS = 128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4;

    always #5 usr_clk = ~usr_clk;

    asi_usr_arb_mem #(.ASI_ARB(0), .SLV_WS(1)) u_a (
        .usr_clk(usr_clk), .usr_reset(usr_reset),
        .usr_rrequest(rreq), .usr_rgrant(a_rgrant), .usr_raddr(raddr), .usr_re(re),
        .usr_rlast(rlast), .usr_rsize(rsize), .usr_rdata(a_rdata), .usr_rsize_error(a_rse),
        .usr_wrequest(wreq), .usr_wgrant(a_wgrant), .usr_waddr(waddr), .usr_we(we),
        .usr_wlast(wlast), .usr_wsize(wsize), .usr_wdata(wdata), .usr_wstrb(wstrb),
        .usr_wsize_error(a_wse));

    asi_usr_arb_mem #(.ASI_ARB(1), .SLV_WS(1)) u_b (
        .usr_clk(usr_clk), .usr_reset(usr_reset),
        .usr_rrequest(rreq), .usr_rgrant(b_rgrant), .usr_raddr(raddr), .usr_re(re),
        .usr_rlast(rlast), .usr_rsize(rsize), .usr_rdata(b_rdata), .usr_rsize_error(b_rse),
        .usr_wrequest(wreq), .usr_wgrant(b_wgrant), .usr_waddr(waddr), .usr_we(we),
        .usr_wlast(wlast), .usr_wsize(wsize), .usr_wdata(wdata), .usr_wstrb(wstrb),
        .usr_wsize_error(b_wse));

    asi_usr_arb_mem #(.ASI_ARB(0), .SLV_WS(3)) u_c (
        .usr_clk(usr_clk), .usr_reset(usr_reset),
        .usr_rrequest(rreq), .usr_rgrant(c_rgrant), .usr_raddr(raddr), .usr_re(re),
        .usr_rlast(rlast), .usr_rsize(rsize), .usr_rdata(c_rdata), .usr_rsize_error(c_rse),
        .usr_wrequest(wreq), .usr_wgrant(c_wgrant), .usr_waddr(waddr), .usr_we(we),
        .usr_wlast(wlast), .usr_wsize(wsize), .usr_wdata(wdata), .usr_wstrb(wstrb),
        .usr_wsize_error(c_wse));

    // Beats on u_a must only occur while the matching grant is held.
    always @(negedge usr_clk) begin
        if (!usr_reset && ((re && !a_rgrant) || (we && !a_wgrant))) begin
            errors++;
            $display("FAIL ungranted_beat: re=%0b rgrant=%0b we=%0b wgrant=%0b", re, a_rgrant, we, a_wgrant);
        end
    end

    function automatic logic [127:0] word_val(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(i);
        return {w, w, w, w};
    endfunction

    task automatic tick;
        @(posedge usr_clk);
        #1;
    endtask

    task automatic idle_in;
        rreq = 0; wreq = 0; re = 0; we = 0; rlast = 0; wlast = 0; wstrb = '0;
    endtask

    task automatic test_reset;
        usr_reset = 1; rreq = 1; wreq = 1;
        tick; tick;
        checks++; if (a_rgrant !== 1'b0) begin errors++; $display("FAIL reset_a_rgrant: got %0b want 0", a_rgrant); end
        checks++; if (a_wgrant !== 1'b0) begin errors++; $display("FAIL reset_a_wgrant: got %0b want 0", a_wgrant); end
        checks++; if (b_rgrant !== 1'b0) begin errors++; $display("FAIL reset_b_rgrant: got %0b want 0", b_rgrant); end
        checks++; if (a_rdata !== 128'h0) begin errors++; $display("FAIL reset_a_rdata: got %h want 0", a_rdata); end
        checks++; if (c_rdata !== 128'h0) begin errors++; $display("FAIL reset_c_rdata: got %h want 0", c_rdata); end
        idle_in;
        usr_reset = 0;
        tick;
    endtask

    task automatic test_read_burst;
        rreq = 1;
        tick;
        checks++; if (a_rgrant !== 1'b1) begin errors++; $display("FAIL rd_grant: got %0b want 1", a_rgrant); end
        rreq = 0;
        for (int i = 0; i < 4; i++) begin
            re = 1; raddr = 40'(i * 16); rlast = (i == 3);
            tick;
            if (i < 3) begin
                checks++; if (a_rgrant !== 1'b1) begin errors++; $display("FAIL rd_hold beat %0d: got %0b want 1", i, a_rgrant); end
            end
        end
        re = 0; rlast = 0;
        checks++; if (a_rgrant !== 1'b0) begin errors++; $display("FAIL rd_release: got %0b want 0", a_rgrant); end
    endtask

    task automatic test_arb_priority;
        rreq = 1; wreq = 1;
        tick;
        checks++; if (a_wgrant !== 1'b1) begin errors++; $display("FAIL prio0_wgrant: got %0b want 1", a_wgrant); end
        checks++; if (a_rgrant !== 1'b0) begin errors++; $display("FAIL prio0_rgrant: got %0b want 0", a_rgrant); end
        checks++; if (b_rgrant !== 1'b1) begin errors++; $display("FAIL prio1_rgrant: got %0b want 1", b_rgrant); end
        checks++; if (b_wgrant !== 1'b0) begin errors++; $display("FAIL prio1_wgrant: got %0b want 0", b_wgrant); end
        we = 1; wlast = 1; waddr = 40'h0; wstrb = '0; wreq = 0;
        tick;
        we = 0; wlast = 0;
        checks++; if (a_rgrant !== 1'b1) begin errors++; $display("FAIL switch_rgrant: got %0b want 1", a_rgrant); end
        checks++; if (a_wgrant !== 1'b0) begin errors++; $display("FAIL switch_wgrant: got %0b want 0", a_wgrant); end
        checks++; if (b_rgrant !== 1'b1) begin errors++; $display("FAIL prio1_hold: got %0b want 1", b_rgrant); end
        re = 1; rlast = 1; raddr = 40'h0; rreq = 0;
        tick;
        re = 0; rlast = 0;
        checks++; if (a_rgrant !== 1'b0) begin errors++; $display("FAIL prio0_idle: got %0b want 0", a_rgrant); end
        checks++; if (b_rgrant !== 1'b0) begin errors++; $display("FAIL prio1_idle: got %0b want 0", b_rgrant); end
    endtask

    task automatic test_fairness;
        logic exp_rd;
        wreq = 1; rreq = 1;
        tick;
        for (int k = 0; k < 7; k++) begin
            exp_rd = (k == 4);
            checks++; if (a_rgrant !== exp_rd) begin errors++; $display("FAIL fair_rgrant burst %0d: got %0b want %0b", k, a_rgrant, exp_rd); end
            checks++; if (a_wgrant !== !exp_rd) begin errors++; $display("FAIL fair_wgrant burst %0d: got %0b want %0b", k, a_wgrant, !exp_rd); end
            for (int bt = 0; bt < 2; bt++) begin
                if (exp_rd) begin
                    re = 1; raddr = 40'h0; rlast = (bt == 1);
                    if (bt == 1) rreq = 0;
                end else begin
                    we = 1; waddr = 40'h0; wstrb = '0; wlast = (bt == 1);
                    if (k == 6 && bt == 1) wreq = 0;
                end
                tick;
                re = 0; we = 0; rlast = 0; wlast = 0;
            end
        end
        checks++; if (a_rgrant !== 1'b0 || a_wgrant !== 1'b0) begin errors++; $display("FAIL fair_idle: got r=%0b w=%0b want 0 0", a_rgrant, a_wgrant); end
    endtask

    task automatic test_strobe_write;
        wreq = 1;
        tick;
        checks++; if (a_wgrant !== 1'b1) begin errors++; $display("FAIL strb_wgrant: got %0b want 1", a_wgrant); end
        we = 1; waddr = 40'h50; wdata = W_FULL; wstrb = 16'hFFFF; wlast = 1;
        tick;
        checks++; if (a_wgrant !== 1'b1) begin errors++; $display("FAIL strb_wgrant2: got %0b want 1", a_wgrant); end
        wdata = '1; wstrb = 16'h0001; wlast = 1; wreq = 0; rreq = 1;
        tick;
        we = 0; wlast = 0; wstrb = '0;
        checks++; if (a_rgrant !== 1'b1) begin errors++; $display("FAIL strb_rgrant: got %0b want 1", a_rgrant); end
        re = 1; raddr = 40'h50; rlast = 1; rreq = 0;
        #1;
        checks++; if (a_rdata === W_STRB) begin errors++; $display("FAIL strb_early: got %h before latency", a_rdata); end
        tick;
        re = 0; rlast = 0;
        checks++; if (a_rdata !== W_STRB) begin errors++; $display("FAIL strb_data: got %h want %h", a_rdata, W_STRB); end
        tick;
        checks++; if (a_rdata !== W_STRB) begin errors++; $display("FAIL strb_hold: got %h want %h", a_rdata, W_STRB); end
        checks++; if (a_rgrant !== 1'b0) begin errors++; $display("FAIL strb_idle: got %0b want 0", a_rgrant); end
    endtask

    task automatic test_back_to_back;
        wreq = 1;
        tick;
        for (int i = 0; i < 8; i++) begin
            we = 1; waddr = 40'(i * 16); wdata = word_val(i); wstrb = 16'hFFFF;
            wlast = (i == 7); wreq = (i != 7);
            tick;
        end
        we = 0; wlast = 0; wstrb = '0;
        rreq = 1;
        tick;
        checks++; if (c_rgrant !== 1'b1) begin errors++; $display("FAIL b2b_rgrant: got %0b want 1", c_rgrant); end
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                re = 1; raddr = 40'(k * 16); rlast = (k == 7); rreq = (k != 7);
            end else begin
                re = 0; rlast = 0;
            end
            tick;
            if (k == 1) begin
                checks++; if (c_rdata !== W_STRB) begin errors++; $display("FAIL b2b_prehold: got %h want %h", c_rdata, W_STRB); end
            end
            if (k >= 2) begin
                checks++; if (c_rdata !== word_val(k - 2)) begin errors++; $display("FAIL b2b_beat %0d: got %h want %h", k - 2, c_rdata, word_val(k - 2)); end
            end
        end
        rreq = 1;
        tick;
        for (int k = 0; k < 3; k++) begin
            re = 1; raddr = 40'((k + 1) * 16); rlast = 0;
            tick;
        end
        re = 0;
        checks++; if (c_rdata !== word_val(1)) begin errors++; $display("FAIL b2b_midstream: got %h want %h", c_rdata, word_val(1)); end
        usr_reset = 1;
        tick;
        checks++; if (c_rdata !== 128'h0) begin errors++; $display("FAIL b2b_rst_data: got %h want 0", c_rdata); end
        checks++; if (c_rgrant !== 1'b0) begin errors++; $display("FAIL b2b_rst_grant: got %0b want 0", c_rgrant); end
        usr_reset = 0; rreq = 0;
        tick; tick;
        checks++; if (c_rdata !== 128'h0) begin errors++; $display("FAIL b2b_discard: got %h want 0", c_rdata); end
    endtask

    task automatic test_size_alias;
        rsize = 3'd5; wsize = 3'd4;
        #1;
        checks++; if (a_rse !== 1'b1) begin errors++; $display("FAIL rsize5_err: got %0b want 1", a_rse); end
        checks++; if (a_wse !== 1'b0) begin errors++; $display("FAIL wsize4_err: got %0b want 0", a_wse); end
        rsize = 3'd4; wsize = 3'd7;
        #1;
        checks++; if (a_rse !== 1'b0) begin errors++; $display("FAIL rsize4_err: got %0b want 0", a_rse); end
        checks++; if (a_wse !== 1'b1) begin errors++; $display("FAIL wsize7_err: got %0b want 1", a_wse); end
        rsize = 3'd0; wsize = 3'd0;
        wreq = 1;
        tick;
        we = 1; waddr = 40'h4000; wdata = W_ALIAS; wstrb = 16'hFFFF; wlast = 1; wreq = 0; rreq = 1;
        tick;
        we = 0; wlast = 0; wstrb = '0;
        re = 1; raddr = 40'h0; rlast = 1; rreq = 0;
        tick;
        re = 0; rlast = 0;
        checks++; if (a_rdata !== W_ALIAS) begin errors++; $display("FAIL alias_word0: got %h want %h", a_rdata, W_ALIAS); end
    endtask

    initial begin
        usr_reset = 1;
        raddr = '0; waddr = '0; rsize = '0; wsize = '0; wdata = '0;
        idle_in;
        test_reset;
        test_read_burst;
        test_arb_priority;
        test_fairness;
        test_strobe_write;
        test_back_to_back;
        test_size_alias;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
